// File: rtl/chunked_adder_if.sv
// chunked_adder_if: operand/result handshake bundle for chunked_adder
interface chunked_adder_if #(parameter int WIDTH = 8);
  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             sub;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH:0]   s;
  logic             ovf;
  modport master (output in_valid, a, b, sub, out_ready, input in_ready, out_valid, s, ovf);
  modport slave  (input in_valid, a, b, sub, out_ready, output in_ready, out_valid, s, ovf);
endinterface

// File: rtl/chunked_adder.sv
// chunked_adder: multi-cycle add/subtract, CHUNK bits per clock LSB-first, with signed overflow
module chunked_adder #(
  parameter int WIDTH = 8,
  parameter int CHUNK = 2
) (
  input logic           clk,
  input logic           rst_n,
  chunked_adder_if.slave bus
);
  localparam int N  = WIDTH / CHUNK;
  localparam int IW = N > 1 ? $clog2(N) : 1;
  typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;
  state_t           state_q, state_d;
  logic [IW-1:0]    idx_q, idx_d;
  logic             carry_q, carry_d;
  logic [WIDTH-1:0] a_q, a_d, b_q, b_d, res_q, res_d;
  logic             cout_q, cout_d, ovf_q, ovf_d;
  logic [CHUNK:0]   sum;
  assign bus.in_ready  = state_q == IDLE;
  assign bus.out_valid = state_q == DONE;
  assign bus.s         = {cout_q, res_q};
  assign bus.ovf       = ovf_q;
  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    carry_d = carry_q;
    a_d     = a_q;
    b_d     = b_q;
    res_d   = res_q;
    cout_d  = cout_q;
    ovf_d   = ovf_q;
    sum     = {1'b0, a_q[idx_q*CHUNK +: CHUNK]} + {1'b0, b_q[idx_q*CHUNK +: CHUNK]} + (CHUNK+1)'(carry_q);
    case (state_q)
      IDLE: if (bus.in_valid) begin
        state_d = BUSY;
        a_d     = bus.a;
        b_d     = bus.sub ? ~bus.b : bus.b;
        carry_d = bus.sub;
        idx_d   = '0;
        res_d   = '0;
        cout_d  = 1'b0;
        ovf_d   = 1'b0;
      end
      BUSY: begin
        res_d[idx_q*CHUNK +: CHUNK] = sum[CHUNK-1:0];
        carry_d = sum[CHUNK];
        idx_d   = idx_q + 1'b1;
        if (idx_q == IW'(N-1)) begin
          state_d = DONE;
          idx_d   = '0;
          cout_d  = sum[CHUNK];
          // carry into the MSB is recovered as r ^ a ^ b at that bit
          ovf_d   = sum[CHUNK] ^ sum[CHUNK-1] ^ a_q[WIDTH-1] ^ b_q[WIDTH-1];
        end
      end
      DONE: state_d = bus.out_ready ? IDLE : DONE;
      default: state_d = IDLE;
    endcase
  end
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= IDLE;
      idx_q   <= '0;
      carry_q <= 1'b0;
      a_q     <= '0;
      b_q     <= '0;
      res_q   <= '0;
      cout_q  <= 1'b0;
      ovf_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      carry_q <= carry_d;
      a_q     <= a_d;
      b_q     <= b_d;
      res_q   <= res_d;
      cout_q  <= cout_d;
      ovf_q   <= ovf_d;
    end
  end
endmodule
